rv32_prog_loader: RTL and testbench



---
 rtl/rv32_prog_loader_pkg.sv | 26 ++
 rtl/rv32_prog_word_asm.sv | 59 +++++
 rtl/rv32_prog_loader.sv | 191 +++++++++++++++++++
 tb/tb_rv32_prog_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_prog_loader_pkg.sv
// Purpose: shared command codes, loader state encoding and address types for the program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_prog_loader_pkg;

    localparam int PROG_ADDR_W = 12;

    typedef logic [PROG_ADDR_W-1:0] rv_imem_addr_t;
    typedef logic [PROG_ADDR_W-1:0] rv_dmem_addr_t;

    localparam logic [7:0] PROG_CMD_IMEM = 8'hA5;
    localparam logic [7:0] PROG_CMD_DMEM = 8'h5A;
    localparam logic [7:0] PROG_CMD_RUN  = 8'hC3;
    localparam logic [7:0] PROG_CMD_HALT = 8'h3C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR0,
        ST_ADDR1,
        ST_CNT0,
        ST_CNT1,
        ST_DATA,
        ST_CSUM
    } prog_state_t;

endpackage

// File: rtl/rv32_prog_word_asm.sv
// Purpose: packs little-endian bytes into 32-bit words, byte k landing in bits [8k+7:8k].
// Latency: word_vld pulses for one cycle, the cycle after the 4th byte is accepted.
// Backpressure: none; a byte is taken every cycle byte_vld is high, buffer re-arms during the pulse.
module rv32_prog_word_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        byte_last,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] buf_q, buf_d;
    logic        word_vld_q, word_vld_d;
    logic [31:0] word_q, word_d;

    assign byte_last = byte_vld & ~clr & (idx_q == 2'd3);
    assign word_vld  = word_vld_q;
    assign word_dat  = word_q;

    // Collect bytes 0..2 in the buffer; the 4th byte completes the word and emits it.
    always_comb begin
        idx_d      = idx_q;
        buf_d      = buf_q;
        word_d     = word_q;
        word_vld_d = 1'b0;
        if (clr) begin
            idx_d = 2'd0;
        end else if (byte_vld) begin
            if (idx_q == 2'd3) begin
                word_d     = {byte_dat, buf_q};
                word_vld_d = 1'b1;
                idx_d      = 2'd0;
            end else begin
                buf_d[{idx_q, 3'b000} +: 8] = byte_dat;
                idx_d                       = idx_q + 2'd1;
            end
        end
    end

    // Assembler state; reset cuts any pulse in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= 2'd0;
            buf_q      <= 24'd0;
            word_q     <= 32'd0;
            word_vld_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
        end
    end

endmodule

// File: rtl/rv32_prog_loader.sv
// Purpose: parses the framed host byte stream into imem/dmem word writes and core reset control.
// Latency: write strobe in the cycle after a word's 4th byte; command effects visible the next cycle.
// Backpressure: never; in_ready is tied high and every byte is consumed in one cycle.
module rv32_prog_loader
    import rv32_prog_loader_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              rv32_io_clk,
    input  logic              rv32_io_rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] prog_imem_addr,
    output logic [DATA_W-1:0] prog_imem_data,
    output logic              prog_imem_w_en,
    output logic [ADDR_W-1:0] prog_dmem_addr,
    output logic [DATA_W-1:0] prog_dmem_data,
    output logic              prog_dmem_w_en,
    output logic              prog_program,
    output logic              core_rst_n,
    output logic              busy,
    output logic              err,
    output logic [15:0]       words_written
);

    prog_state_t       state_q, state_d;
    logic [15:0]       addr_q, addr_d;      // full 16-bit frame address; low ADDR_W bits used
    logic [15:0]       cnt_q, cnt_d;        // words remaining in the frame
    logic [7:0]        sum_q, sum_d;
    logic              dmem_q, dmem_d;      // target of the current frame
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_last_q, wr_last_d;
    logic              prog_q, prog_d;
    logic              core_rst_q, core_rst_d;
    logic              err_q, err_d;
    logic [15:0]       words_q, words_d;

    logic              byte_acc;
    logic              byte_last;
    logic              word_vld;
    logic [31:0]       word_dat;

    assign in_ready = 1'b1;
    assign byte_acc = in_valid;

    rv32_prog_word_asm u_word_asm (
        .clk       (rv32_io_clk),
        .rst_n     (rv32_io_rst_n),
        .clr       (state_q != ST_DATA),
        .byte_vld  (byte_acc),
        .byte_dat  (in_data),
        .byte_last (byte_last),
        .word_vld  (word_vld),
        .word_dat  (word_dat)
    );

    assign prog_imem_addr = wr_addr_q;
    assign prog_dmem_addr = wr_addr_q;
    assign prog_imem_data = word_dat;
    assign prog_dmem_data = word_dat;
    assign prog_imem_w_en = word_vld & ~dmem_q;
    assign prog_dmem_w_en = word_vld &  dmem_q;
    assign prog_program   = prog_q;
    assign core_rst_n     = core_rst_q;
    assign busy           = (state_q != ST_IDLE);
    assign err            = err_q;
    assign words_written  = words_q;

    // Frame parser: one state step per accepted byte, plus write bookkeeping.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        dmem_d     = dmem_q;
        wr_addr_d  = wr_addr_q;
        wr_last_d  = wr_last_q;
        prog_d     = prog_q;
        core_rst_d = core_rst_q;
        err_d      = err_q;
        words_d    = words_q;

        if (word_vld) begin
            if (words_q != 16'hFFFF) begin
                words_d = words_q + 16'd1;
            end
            // Program select drops right after the final dmem strobe.
            if (dmem_q && wr_last_q) begin
                prog_d = 1'b0;
            end
        end

        if (byte_acc) begin
            case (state_q)
                ST_IDLE: begin
                    case (in_data)
                        PROG_CMD_IMEM: begin
                            state_d    = ST_ADDR0;
                            dmem_d     = 1'b0;
                            sum_d      = 8'd0;
                            core_rst_d = 1'b0;
                            prog_d     = 1'b0;
                        end
                        PROG_CMD_DMEM: begin
                            state_d    = ST_ADDR0;
                            dmem_d     = 1'b1;
                            sum_d      = 8'd0;
                            core_rst_d = 1'b0;
                            prog_d     = 1'b1;
                        end
                        PROG_CMD_RUN:  core_rst_d = 1'b1;
                        PROG_CMD_HALT: core_rst_d = 1'b0;
                        default:       err_d      = 1'b1;
                    endcase
                end
                ST_ADDR0: begin
                    addr_d  = {8'h00, in_data};
                    sum_d   = sum_q + in_data;
                    state_d = ST_ADDR1;
                end
                ST_ADDR1: begin
                    addr_d  = {in_data, addr_q[7:0]};
                    sum_d   = sum_q + in_data;
                    state_d = ST_CNT0;
                end
                ST_CNT0: begin
                    cnt_d   = {8'h00, in_data};
                    sum_d   = sum_q + in_data;
                    state_d = ST_CNT1;
                end
                ST_CNT1: begin
                    cnt_d   = {in_data, cnt_q[7:0]};
                    sum_d   = sum_q + in_data;
                    state_d = ((in_data != 8'd0) || (cnt_q[7:0] != 8'd0)) ? ST_DATA : ST_CSUM;
                end
                ST_DATA: begin
                    sum_d = sum_q + in_data;
                    if (byte_last) begin
                        wr_addr_d = addr_q[ADDR_W-1:0];
                        addr_d    = addr_q + 16'd1;
                        wr_last_d = (cnt_q == 16'd1);
                        cnt_d     = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (in_data != sum_q) begin
                        err_d = 1'b1;
                    end
                    prog_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Loader registers; reset holds the core and discards any partial frame.
    always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
        if (!rv32_io_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= 16'd0;
            cnt_q      <= 16'd0;
            sum_q      <= 8'd0;
            dmem_q     <= 1'b0;
            wr_addr_q  <= '0;
            wr_last_q  <= 1'b0;
            prog_q     <= 1'b0;
            core_rst_q <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            dmem_q     <= dmem_d;
            wr_addr_q  <= wr_addr_d;
            wr_last_q  <= wr_last_d;
            prog_q     <= prog_d;
            core_rst_q <= core_rst_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

endmodule

// File: tb/tb_rv32_prog_loader.sv
// Purpose: self-checking bench for rv32_prog_loader with a write scoreboard and frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rv32_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] imem_addr, dmem_addr;
    logic [31:0] imem_data, dmem_data;
    logic        imem_w_en, dmem_w_en;
    logic        prog_program, core_rst_n, busy, err;
    logic [15:0] words_written;

    always #5 clk = ~clk;

    rv32_prog_loader dut (
        .rv32_io_clk    (clk),
        .rv32_io_rst_n  (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .prog_imem_addr (imem_addr),
        .prog_imem_data (imem_data),
        .prog_imem_w_en (imem_w_en),
        .prog_dmem_addr (dmem_addr),
        .prog_dmem_data (dmem_data),
        .prog_dmem_w_en (dmem_w_en),
        .prog_program   (prog_program),
        .core_rst_n     (core_rst_n),
        .busy           (busy),
        .err            (err),
        .words_written  (words_written)
    );

    typedef struct packed {
        logic        dm;
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] fw[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        exp_err  = 1'b0;
    int          exp_words = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every strobe cycle consumes exactly one expected write.
    always @(negedge clk) begin
        if (rst_n && (imem_w_en || dmem_w_en)) begin
            wr_t e;
            check("single_strobe", {62'd0, imem_w_en, dmem_w_en} == 64'd3, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("wr_target", dmem_w_en, e.dm);
                check("wr_addr", dmem_w_en ? dmem_addr : imem_addr, e.a);
                check("wr_data", dmem_w_en ? dmem_data : imem_data, e.d);
                check("prog_during_write", prog_program, e.dm);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full frame from fw[]; cs_ovr < 0 sends the correct checksum.
    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                              input int cs_ovr, input int gmax);
        int         n;
        logic [7:0] sum;
        logic [7:0] bs[$];
        logic [7:0] cs;
        wr_t        e;
        logic       dm;
        dm = (cmd == 8'h5A);
        n  = fw.size();
        bs = {addr[7:0], addr[15:8], 8'(n), 8'(n >> 8)};
        for (int i = 0; i < n; i++) begin
            e.dm = dm;
            e.a  = 12'((int'(addr) + i) % 4096);
            e.d  = fw[i];
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) bs.push_back(8'(fw[i] >> (8 * k)));
        end
        sum = 8'd0;
        foreach (bs[j]) sum = sum + bs[j];
        cs = (cs_ovr >= 0) ? 8'(cs_ovr) : sum;
        if (cs != sum) exp_err = 1'b1;
        exp_words = (exp_words + n > 65535) ? 65535 : exp_words + n;

        send_byte(cmd, 0);
        check("prog_after_cmd", prog_program, dm);
        check("core_held_after_cmd", core_rst_n, 1'b0);
        check("busy_in_frame", busy, 1'b1);
        for (int j = 0; j < bs.size(); j++)
            send_byte(bs[j], (j == bs.size() - 1) ? 0 : $urandom_range(0, gmax));
        if (n > 0) check("prog_at_last_pulse", prog_program, dm);
        send_byte(cs, 0);
        check("prog_after_csum", prog_program, 1'b0);
        idle(3);
        check("err", err, exp_err);
        check("words_written", words_written, exp_words[15:0]);
        check("busy_after_frame", busy, 1'b0);
        check("core_held_after_frame", core_rst_n, 1'b0);
        check("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_outputs", {imem_w_en, dmem_w_en, prog_program, core_rst_n, busy, err}, 6'd0);
        check("rst_words", words_written, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-word imem load at 0x010
        fw = {32'h12345678, 32'hDEADBEEF};
        send_frame(8'hA5, 16'h0010, -1, 2);

        // Dmem load wrapping 0xFFF -> 0x000, bytes back-to-back
        fw = {32'hCAFEF00D, 32'h01020304};
        send_frame(8'h5A, 16'h0FFF, -1, 0);

        // RUN then an empty imem frame re-holds the core
        send_byte(8'hC3, 0);
        check("run_releases_core", core_rst_n, 1'b1);
        fw = {};
        send_frame(8'hA5, 16'h0000, -1, 1);

        // Unknown command
        send_byte(8'h77, 0);
        exp_err = 1'b1;
        check("unknown_cmd_err", err, 1'b1);
        check("unknown_cmd_idle", busy, 1'b0);
        fw = {32'hA5A55A5A};
        send_frame(8'h5A, 16'h0123, -1, 1);

        // Asynchronous reset after the 2nd data byte
        send_byte(8'hA5, 0);
        send_byte(8'h20, 0); send_byte(8'h00, 0);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_outputs", {imem_w_en, dmem_w_en, prog_program, core_rst_n, busy, err}, 6'd0);
        check("arst_words", words_written, 16'd0);
        check("arst_in_ready", in_ready, 1'b1);
        exp_err = 1'b0;
        exp_words = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        fw = {32'h0BADF00D, 32'h76543210, 32'h89ABCDEF};
        send_frame(8'hA5, 16'hF7FE, -1, 1);

        // Bad checksum then a good frame: err stays set
        fw = {32'h12345678, 32'hDEADBEEF};
        send_frame(8'hA5, 16'h0010, 0, 1);
        send_frame(8'h5A, 16'h0200, -1, 1);

        // Randomized mix of frames and run/halt commands
        for (int it = 0; it < 25; it++) begin
            int r;
            r = $urandom_range(0, 5);
            if (r == 0) begin
                send_byte(8'hC3, $urandom_range(0, 2));
                check("rand_run", core_rst_n, 1'b1);
            end else if (r == 1) begin
                send_byte(8'h3C, $urandom_range(0, 2));
                check("rand_halt", core_rst_n, 1'b0);
            end else begin
                int n;
                n  = $urandom_range(0, 4);
                fw = {};
                for (int i = 0; i < n; i++) fw.push_back($urandom);
                send_frame(($urandom_range(0, 1) == 1) ? 8'h5A : 8'hA5,
                           16'($urandom), ($urandom_range(0, 7) == 0) ? 8'($urandom) : -1,
                           $urandom_range(0, 2));
            end
        end

        idle(5);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
